hazard_stall_ctrl: RTL
======================

// Module: hazard_stall_ctrl
// PURPOSE
// - Pipeline stall/flush controller for the 5-stage MIPS core; sits beside the forwarding unit.
// - Detects load-use hazards that forwarding cannot cover and inserts one bubble.
// - Sequences multi-cycle mult/div occupancy of EX, and flushes IF/ID on taken branch/jump.
// - Drives PC, IF/ID and ID/EX pipeline-register control.
// PARAMETERS
// - MD_LATENCY  4  EX cycles a mult/div occupies; legal range 1..15
// PORTS
// - clk           in   1  pipeline clock, all state on rising edge
// - rst           in   1  synchronous reset, active-high
// - ID_Rs         in   5  rs of instruction in ID
// - ID_Rt         in   5  rt of instruction in ID
// - ID_usesRt     in   1  ID instruction reads rt as a source
// - EX_Rd         in   5  destination register of instruction in EX
// - EX_memRead    in   1  instruction in EX is a load
// - md_start      in   1  instruction in ID is mult/div
// - branch_taken  in   1  branch resolved taken in ID
// - jump          in   1  jump decoded in ID
// - pc_write      out  1  PC load enable
// - IFID_write    out  1  IF/ID register enable
// - IFID_flush    out  1  clear IF/ID to nop
// - IDEX_bubble   out  1  zero ID/EX control signals (insert nop)
// - md_busy       out  1  mult/div occupying EX
// BEHAVIOUR
// - One clock (clk); rst is synchronous and active-high.
// - Reset: state=RUN, cnt=0. While rst=1, outputs are forced to pc_write=1, IFID_write=1,
//   IFID_flush=0, IDEX_bubble=0, md_busy=0, regardless of inputs.
// - Outputs are combinational (Mealy) from state and inputs; zero-cycle latency.
// - lu = EX_memRead && EX_Rd!=0 && (EX_Rd==ID_Rs || (ID_usesRt && EX_Rd==ID_Rt)).
// - Register 0 never raises a hazard.
// - State RUN:
//   - lu=1: pc_write=0, IFID_write=0, IDEX_bubble=1, IFID_flush=0. Stay in RUN.
//     md_start and branch_taken/jump are ignored this cycle; the ID instruction is re-presented.
//   - lu=0, md_start=1: normal flow (enables=1, bubble=0).
//     If MD_LATENCY>1, go to MD_WAIT with cnt=MD_LATENCY-1; if MD_LATENCY==1, stay in RUN.
//   - lu=0, (branch_taken|jump)=1: IFID_flush=1, pc_write=1, IFID_write=1.
//     md_start and branch are mutually exclusive by decode.
//   - Otherwise: pc_write=1, IFID_write=1, flush=0, bubble=0.
// - State MD_WAIT:
//   - pc_write=0, IFID_write=0, IDEX_bubble=1, md_busy=1, IFID_flush=0.
//   - lu, md_start, branch_taken and jump are all ignored.
//   - cnt decrements each cycle; when cnt==1 the next state is RUN, so MD_WAIT lasts exactly
//     MD_LATENCY-1 cycles.
// - md_busy=0 in RUN.
// - cnt is 4 bits and never wraps: it is loaded only on entry to MD_WAIT.
// - rst mid-MD_WAIT: RUN on the next edge, cnt=0; the aborted op is discarded.
// CONFIGURATION
// - HAZARD_PERF_EN defined:
//   - Adds output stall_cycles [31:0], counting cycles with IDEX_bubble=1.
//   - Adds output flush_count [15:0], counting cycles with IFID_flush=1.
//   - Both counters saturate at all-ones and reset to 0 on rst.
// - HAZARD_PERF_EN undefined: both ports and counters are absent; all other behaviour is identical.
// TESTING
// - EX_memRead=1, EX_Rd=8, ID_Rs=8, one cycle -> pc_write=0, IFID_write=0, IDEX_bubble=1;
//   next cycle with EX_memRead=0 -> all normal.
// - EX_memRead=1, EX_Rd=0, ID_Rs=0 -> no stall (pc_write=1, IDEX_bubble=0).
// - EX_memRead=1, EX_Rd=8, ID_Rt=8, ID_usesRt=0, ID_Rs=3 -> no stall;
//   with ID_usesRt=1 -> stall.
// - MD_LATENCY=4, md_start pulse at cycle 0 -> cycle 0 normal;
//   cycles 1-3 md_busy=1, IDEX_bubble=1, pc_write=0; cycle 4 RUN.
// - branch_taken=1 with lu=1 -> IFID_flush=0, stall;
//   next cycle lu=0, branch_taken=1 -> IFID_flush=1, pc_write=1.
// - rst=1 in second MD_WAIT cycle -> following cycle md_busy=0, pc_write=1;
//   with HAZARD_PERF_EN, stall_cycles=0.

Source files
------------

// File: rtl/hazard_stall_ctrl_if.sv
// rtl/hazard_stall_ctrl_if.sv - hazard/stall controller pipeline-control bundle
interface hazard_stall_ctrl_if;
  // ID-stage source operands
  logic [4:0] ID_Rs;
  logic [4:0] ID_Rt;
  logic       ID_usesRt;
  // EX-stage producer
  logic [4:0] EX_Rd;
  logic       EX_memRead;
  // ID-stage decode events
  logic       md_start;
  logic       branch_taken;
  logic       jump;
  // pipeline-register control
  logic       pc_write;
  logic       IFID_write;
  logic       IFID_flush;
  logic       IDEX_bubble;
  logic       md_busy;

  // pipeline side: supplies decode/hazard info, consumes control
  modport master (
    output ID_Rs,
    output ID_Rt,
    output ID_usesRt,
    output EX_Rd,
    output EX_memRead,
    output md_start,
    output branch_taken,
    output jump,
    input  pc_write,
    input  IFID_write,
    input  IFID_flush,
    input  IDEX_bubble,
    input  md_busy
  );

  // controller side
  modport slave (
    input  ID_Rs,
    input  ID_Rt,
    input  ID_usesRt,
    input  EX_Rd,
    input  EX_memRead,
    input  md_start,
    input  branch_taken,
    input  jump,
    output pc_write,
    output IFID_write,
    output IFID_flush,
    output IDEX_bubble,
    output md_busy
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use stall, mult/div occupancy and branch flush control (optional HAZARD_PERF_EN)
module hazard_stall_ctrl #(
  parameter int unsigned MD_LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_stall_ctrl_if.slave   bus
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]          stall_cycles,
  output logic [15:0]          flush_count
`endif
);

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } state_t;

  // MD_WAIT covers the EX cycles after the issue cycle, hence the minus one
  localparam logic [3:0] MD_LOAD  = 4'(MD_LATENCY - 1);
  localparam bit         MD_MULTI = (MD_LATENCY > 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic load_use;
  logic redirect;
  logic pc_write_c;
  logic ifid_write_c;
  logic ifid_flush_c;
  logic idex_bubble_c;
  logic md_busy_c;

  // load-use hazard that forwarding cannot resolve; r0 is never a real dependency
  always_comb begin
    load_use = 1'b0;
    if (bus.EX_memRead && (bus.EX_Rd != 5'd0)) begin
      if (bus.EX_Rd == bus.ID_Rs) begin
        load_use = 1'b1;
      end else if (bus.ID_usesRt && (bus.EX_Rd == bus.ID_Rt)) begin
        load_use = 1'b1;
      end
    end
  end

  assign redirect = bus.branch_taken | bus.jump;

  // next-state and Mealy control outputs; reset forces free-running pipeline control
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_write_c    = 1'b1;
    ifid_write_c  = 1'b1;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;
    md_busy_c     = 1'b0;

    if (rst) begin
      state_d = ST_RUN;
      cnt_d   = 4'd0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (load_use) begin
            // hold PC and IF/ID so the dependent instruction is re-presented
            pc_write_c    = 1'b0;
            ifid_write_c  = 1'b0;
            idex_bubble_c = 1'b1;
          end else if (bus.md_start) begin
            // mult/div issues normally this cycle, then owns EX
            if (MD_MULTI) begin
              state_d = ST_MD_WAIT;
              cnt_d   = MD_LOAD;
            end
          end else if (redirect) begin
            ifid_flush_c = 1'b1;
          end
        end
        ST_MD_WAIT: begin
          // EX is occupied; every other request waits
          pc_write_c    = 1'b0;
          ifid_write_c  = 1'b0;
          idex_bubble_c = 1'b1;
          md_busy_c     = 1'b1;
          if (cnt_q <= 4'd1) begin
            state_d = ST_RUN;
            cnt_d   = 4'd0;
          end else begin
            cnt_d   = cnt_q - 4'd1;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = 4'd0;
        end
      endcase
    end
  end

  // state and occupancy counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pc_write    = pc_write_c;
  assign bus.IFID_write  = ifid_write_c;
  assign bus.IFID_flush  = ifid_flush_c;
  assign bus.IDEX_bubble = idex_bubble_c;
  assign bus.md_busy     = md_busy_c;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_count_q, flush_count_d;

  // saturating event counts of bubble and flush cycles
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (idex_bubble_c && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (ifid_flush_c && (flush_count_q != 16'hFFFF)) begin
      flush_count_d = flush_count_q + 16'd1;
    end
  end

  // performance counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= 32'd0;
      flush_count_q  <= 16'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule
